// File: rtl/sobel_frame_ctrl_if.sv
// Signal bundle between the Sobel frame sequencer and its environment.
// The sequencer uses the slave modport. The environment uses the master modport.
interface sobel_frame_ctrl_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              Start;
    logic              Abort;
    logic [7:0]        T_in;
    logic [ADDR_W-1:0] Rd_Addr;
    logic [7:0]        Rd_Data;
    logic              Dp_Reset;
    logic              Dp_Enable;
    logic [7:0]        Dp_DataIn;
    logic [7:0]        Dp_T;
    logic [7:0]        Dp_Out_Row;
    logic [7:0]        Dp_Out_Column;
    logic              Dp_isReady;
    logic              Dp_isEnd;
    logic              Dp_Dop;
    logic              Wr_En;
    logic [ADDR_W-1:0] Wr_Addr;
    logic              Wr_Data;
    logic              Busy;
    logic              Done;
    logic              Error;
    logic [ADDR_W-1:0] Result_Count;

    modport master (
        output Start, Abort, T_in, Rd_Data,
        output Dp_Out_Row, Dp_Out_Column, Dp_isReady, Dp_isEnd, Dp_Dop,
        input  Rd_Addr, Dp_Reset, Dp_Enable, Dp_DataIn, Dp_T,
        input  Wr_En, Wr_Addr, Wr_Data, Busy, Done, Error, Result_Count
    );

    modport slave (
        input  Start, Abort, T_in, Rd_Data,
        input  Dp_Out_Row, Dp_Out_Column, Dp_isReady, Dp_isEnd, Dp_Dop,
        output Rd_Addr, Dp_Reset, Dp_Enable, Dp_DataIn, Dp_T,
        output Wr_En, Wr_Addr, Wr_Data, Busy, Done, Error, Result_Count
    );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: streams one IMG_W x IMG_H frame from the pixel ROM through the Sobel Datapath into the result RAM.
// Defining SOBEL_CTRL_WDOG_EN adds a DRAIN watchdog that ends the frame with Error after DRAIN_MAX cycles.
module sobel_frame_ctrl #(
    parameter int unsigned IMG_W     = 256,
    parameter int unsigned IMG_H     = 256,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DRAIN_MAX = 1024
) (
    input  logic              Clk,
    input  logic              Reset,
    sobel_frame_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam int unsigned PIX_LAST = IMG_W * IMG_H - 1;

    if (IMG_W < 3 || IMG_H < 3 || DRAIN_MAX < 1 || DRAIN_MAX > 65536 ||
        (64'(IMG_W) * 64'(IMG_H)) > (64'(1) << ADDR_W)) begin : g_bad_params
        $error("sobel_frame_ctrl: illegal parameter set");
    end

    logic [2:0]        r_state,     w_state_nxt;
    logic              r_clr_cnt,   w_clr_cnt_nxt;
    logic [ADDR_W-1:0] r_rd_addr,   w_rd_addr_nxt;
    logic [7:0]        r_dp_t,      w_dp_t_nxt;
    logic              r_error,     w_error_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_dp_reset,  w_dp_reset_nxt;
    logic              r_dp_enable, w_dp_enable_nxt;
    logic              r_pix_valid, w_pix_valid_nxt;
    logic              w_clear_count;
    logic              w_wdog_hit;

    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_data;
    logic [ADDR_W-1:0] r_result_count;
    logic [ADDR_W-1:0] w_wr_addr;

`ifdef SOBEL_CTRL_WDOG_EN
    logic [15:0] r_wdog_cnt;

    // Counts DRAIN cycles; held at zero outside DRAIN so it restarts on every entry.
    always_ff @(posedge Clk) begin
        if (Reset || r_state != S_DRAIN) begin
            r_wdog_cnt <= 16'd0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
        end
    end

    assign w_wdog_hit = (r_state == S_DRAIN) && (r_wdog_cnt == 16'(DRAIN_MAX - 1));
`else
    assign w_wdog_hit = 1'b0;
`endif

    // State and registered control outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_clr_cnt   <= 1'b0;
            r_rd_addr   <= '0;
            r_dp_t      <= 8'd0;
            r_error     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dp_reset  <= 1'b1;
            r_dp_enable <= 1'b0;
            r_pix_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_dp_t      <= w_dp_t_nxt;
            r_error     <= w_error_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_dp_reset  <= w_dp_reset_nxt;
            r_dp_enable <= w_dp_enable_nxt;
            r_pix_valid <= w_pix_valid_nxt;
        end
    end

    // Next state. Outputs are decoded from the next state so that they line up with the state they describe.
    always_comb begin
        w_state_nxt     = r_state;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_rd_addr_nxt   = r_rd_addr;
        w_dp_t_nxt      = r_dp_t;
        w_error_nxt     = r_error;
        w_pix_valid_nxt = 1'b0;
        w_clear_count   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.Start) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = 1'b0;
                    w_rd_addr_nxt = '0;
                    w_dp_t_nxt    = bus.T_in;
                    w_error_nxt   = 1'b0;
                    w_clear_count = 1'b1;
                end
            end
            S_CLEAR: begin
                if (bus.Abort) begin
                    w_state_nxt = S_FINISH;
                    w_error_nxt = 1'b1;
                end else if (r_clr_cnt) begin
                    w_state_nxt = S_STREAM;
                end else begin
                    w_clr_cnt_nxt = 1'b1;
                end
            end
            S_STREAM: begin
                if (bus.Abort) begin
                    w_state_nxt = S_FINISH;
                    w_error_nxt = 1'b1;
                end else begin
                    w_pix_valid_nxt = 1'b1;
                    if (r_rd_addr == ADDR_W'(PIX_LAST)) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (bus.Abort || (w_wdog_hit && !bus.Dp_isEnd)) begin
                    w_state_nxt = S_FINISH;
                    w_error_nxt = 1'b1;
                end else if (bus.Dp_isEnd) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_done_nxt      = (w_state_nxt == S_FINISH);
        w_dp_reset_nxt  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_CLEAR);
        w_dp_enable_nxt = (w_state_nxt == S_DRAIN) ||
                          ((w_state_nxt == S_STREAM) && (r_state == S_STREAM));
    end

    assign w_wr_addr = ADDR_W'(bus.Dp_Out_Row) * ADDR_W'(IMG_W) + ADDR_W'(bus.Dp_Out_Column);

    // Result write path runs in every state; the count saturates and is cleared by an accepted Start.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= 1'b0;
            r_result_count <= '0;
        end else begin
            r_wr_en <= bus.Dp_isReady;
            if (bus.Dp_isReady) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= bus.Dp_Dop;
            end
            if (w_clear_count) begin
                r_result_count <= '0;
            end else if (bus.Dp_isReady && (r_result_count != '1)) begin
                r_result_count <= r_result_count + ADDR_W'(1);
            end
        end
    end

    assign bus.Rd_Addr      = r_rd_addr;
    assign bus.Dp_Reset     = r_dp_reset;
    assign bus.Dp_Enable    = r_dp_enable;
    assign bus.Dp_DataIn    = r_pix_valid ? bus.Rd_Data : 8'd0;
    assign bus.Dp_T         = r_dp_t;
    assign bus.Wr_En        = r_wr_en;
    assign bus.Wr_Addr      = r_wr_addr;
    assign bus.Wr_Data      = r_wr_data;
    assign bus.Busy         = r_busy;
    assign bus.Done         = r_done;
    assign bus.Error        = r_error;
    assign bus.Result_Count = r_result_count;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 4x4 frame with a sync ROM and a behavioural Datapath model.
`timescale 1ns/1ps
module tb_sobel_frame_ctrl;
    localparam int unsigned IMG_W = 4, IMG_H = 4, ADDR_W = 4, DRAIN_MAX = 20;
    localparam int NPIX = 16;
    localparam int LAT  = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   end_en = 1'b1;
    logic [7:0] rom [NPIX];
    int   ecnt;
    int   j;

    sobel_frame_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    sobel_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DRAIN_MAX(DRAIN_MAX)) dut (
        .Clk(clk), .Reset(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) bus.Rd_Data <= rom[bus.Rd_Addr];

    // Datapath model: result j appears after LAT+j enabled cycles; row/col from j; the Dop bit is j's LSB.
    always @(posedge clk) begin
        if (rst || bus.Dp_Reset) begin
            ecnt <= 0;
            bus.Dp_isReady <= 1'b0; bus.Dp_isEnd <= 1'b0; bus.Dp_Dop <= 1'b0;
            bus.Dp_Out_Row <= 8'd0; bus.Dp_Out_Column <= 8'd0;
        end else if (bus.Dp_Enable) begin
            if (ecnt >= LAT && ecnt < LAT + NPIX) begin
                j = ecnt - LAT;
                bus.Dp_isReady    <= 1'b1;
                bus.Dp_Out_Row    <= 8'(j / 4);
                bus.Dp_Out_Column <= 8'(j % 4);
                bus.Dp_Dop        <= j[0];
                bus.Dp_isEnd      <= end_en && (j == NPIX - 1);
            end else begin
                bus.Dp_isReady <= 1'b0; bus.Dp_isEnd <= 1'b0;
            end
            ecnt <= ecnt + 1;
        end else begin
            bus.Dp_isReady <= 1'b0; bus.Dp_isEnd <= 1'b0;
        end
    end

    task automatic start_frame(input logic [7:0] t);
        @(negedge clk); bus.Start = 1'b1; bus.T_in = t;
        @(negedge clk); bus.Start = 1'b0; bus.T_in = 8'd0;
    endtask

    task automatic run_to_done(input int budget, output int ready_cnt, output int done_cnt, output bit timeout);
        ready_cnt = 0; done_cnt = 0; timeout = 1'b1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.Dp_isReady) ready_cnt++;
            if (bus.Done) begin done_cnt++; timeout = 1'b0; break; end
        end
        if (!timeout) repeat (3) begin @(negedge clk); if (bus.Done) done_cnt++; end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.Start = 1'b0; bus.Abort = 1'b0; bus.T_in = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.Dp_Reset !== 1'b1) begin errors++; $display("FAIL reset_dp_reset got %b exp 1", bus.Dp_Reset); end
            checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.Busy); end
            checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.Done); end
            checks++; if (bus.Wr_En !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", bus.Wr_En); end
            checks++; if (bus.Rd_Addr !== 4'd0) begin errors++; $display("FAIL reset_rd_addr got %0d exp 0", bus.Rd_Addr); end
        end
        checks++; if (bus.Dp_T !== 8'd0) begin errors++; $display("FAIL reset_dp_t got %0d exp 0", bus.Dp_T); end
        checks++; if (bus.Error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", bus.Error); end
        checks++; if (bus.Result_Count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.Result_Count); end
        checks++; if (bus.Dp_Enable !== 1'b0) begin errors++; $display("FAIL reset_dp_enable got %b exp 0", bus.Dp_Enable); end
    endtask

    task automatic test_frame;
        int ready, rdy2, dn; bit to;
        ready = 0;
        start_frame(8'd20);
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL clear1_busy got %b exp 1", bus.Busy); end
        checks++; if (bus.Dp_T !== 8'd20) begin errors++; $display("FAIL clear1_dp_t got %0d exp 20", bus.Dp_T); end
        checks++; if (bus.Dp_Reset !== 1'b1) begin errors++; $display("FAIL clear1_dp_reset got %b exp 1", bus.Dp_Reset); end
        checks++; if (bus.Dp_Enable !== 1'b0) begin errors++; $display("FAIL clear1_dp_enable got %b exp 0", bus.Dp_Enable); end
        @(negedge clk);
        checks++; if (bus.Dp_Reset !== 1'b1) begin errors++; $display("FAIL clear2_dp_reset got %b exp 1", bus.Dp_Reset); end
        checks++; if (bus.Rd_Addr !== 4'd0) begin errors++; $display("FAIL clear2_rd_addr got %0d exp 0", bus.Rd_Addr); end
        for (int k = 0; k < NPIX; k++) begin
            @(negedge clk);
            if (bus.Dp_isReady) ready++;
            checks++; if (bus.Rd_Addr !== 4'(k)) begin errors++; $display("FAIL stream_addr k=%0d got %0d exp %0d", k, bus.Rd_Addr, k); end
            checks++; if (bus.Dp_Reset !== 1'b0) begin errors++; $display("FAIL stream_dp_reset k=%0d got %b exp 0", k, bus.Dp_Reset); end
            checks++; if (bus.Dp_Enable !== (k != 0)) begin errors++; $display("FAIL stream_enable k=%0d got %b exp %b", k, bus.Dp_Enable, k != 0); end
            if (k > 0) begin
                checks++; if (bus.Dp_DataIn !== rom[k-1]) begin errors++; $display("FAIL stream_pixel k=%0d got %0d exp %0d", k, bus.Dp_DataIn, rom[k-1]); end
            end
        end
        @(negedge clk);
        if (bus.Dp_isReady) ready++;
        checks++; if (bus.Dp_Enable !== 1'b1) begin errors++; $display("FAIL drain1_enable got %b exp 1", bus.Dp_Enable); end
        checks++; if (bus.Dp_DataIn !== rom[15]) begin errors++; $display("FAIL drain1_pixel got %0d exp %0d", bus.Dp_DataIn, rom[15]); end
        @(negedge clk);
        if (bus.Dp_isReady) ready++;
        checks++; if (bus.Dp_Enable !== 1'b1) begin errors++; $display("FAIL drain2_enable got %b exp 1", bus.Dp_Enable); end
        checks++; if (bus.Dp_DataIn !== 8'd0) begin errors++; $display("FAIL drain2_pixel got %0d exp 0", bus.Dp_DataIn); end
        run_to_done(40, rdy2, dn, to);
        ready += rdy2;
        checks++; if (to) begin errors++; $display("FAIL frame_timeout got timeout exp done"); end
        checks++; if (dn != 1) begin errors++; $display("FAIL frame_done_pulses got %0d exp 1", dn); end
        checks++; if (ready != NPIX) begin errors++; $display("FAIL frame_ready_pulses got %0d exp 16", ready); end
        checks++; if (bus.Result_Count !== 4'd15) begin errors++; $display("FAIL frame_count_sat got %0d exp 15", bus.Result_Count); end
        checks++; if (bus.Wr_Addr !== 4'd15) begin errors++; $display("FAIL frame_last_addr got %0d exp 15", bus.Wr_Addr); end
        checks++; if (bus.Error !== 1'b0) begin errors++; $display("FAIL frame_error got %b exp 0", bus.Error); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end got %b exp 0", bus.Busy); end
        checks++; if (bus.Dp_T !== 8'd20) begin errors++; $display("FAIL frame_dp_t_hold got %0d exp 20", bus.Dp_T); end
    endtask

    task automatic test_write_path;
        int rdy, dn; bit to; bit found;
        found = 1'b0;
        start_frame(8'd20);
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (bus.Dp_isReady && bus.Dp_Out_Row == 8'd2 && bus.Dp_Out_Column == 8'd3) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL wr_seen got none exp row2_col3"); end
        @(negedge clk);
        checks++; if (bus.Wr_En !== 1'b1) begin errors++; $display("FAIL wr_en got %b exp 1", bus.Wr_En); end
        checks++; if (bus.Wr_Addr !== 4'd11) begin errors++; $display("FAIL wr_addr got %0d exp 11", bus.Wr_Addr); end
        checks++; if (bus.Wr_Data !== 1'b1) begin errors++; $display("FAIL wr_data got %b exp 1", bus.Wr_Data); end
        checks++; if (bus.Result_Count !== 4'd12) begin errors++; $display("FAIL wr_count got %0d exp 12", bus.Result_Count); end
        run_to_done(40, rdy, dn, to);
        checks++; if (to || dn != 1) begin errors++; $display("FAIL wr_frame_done got %0d exp 1", dn); end
    endtask

    task automatic test_abort;
        int rdy, dn; bit to; bit found;
        found = 1'b0;
        start_frame(8'd20);
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk);
            if (bus.Rd_Addr == 4'd7) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_addr7 got none exp 7"); end
        bus.Abort = 1'b1;
        @(negedge clk); bus.Abort = 1'b0;
        checks++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL abort_done got %b exp 1", bus.Done); end
        checks++; if (bus.Error !== 1'b1) begin errors++; $display("FAIL abort_error got %b exp 1", bus.Error); end
        checks++; if (bus.Dp_Enable !== 1'b0) begin errors++; $display("FAIL abort_enable got %b exp 0", bus.Dp_Enable); end
        @(negedge clk);
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy got %b exp 0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL abort_done_once got %b exp 0", bus.Done); end
        checks++; if (bus.Error !== 1'b1) begin errors++; $display("FAIL abort_sticky got %b exp 1", bus.Error); end
        bus.Abort = 1'b1;
        @(negedge clk); bus.Abort = 1'b0;
        checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin errors++; $display("FAIL abort_idle_ignored got done=%b busy=%b exp 0 0", bus.Done, bus.Busy); end
        bus.Abort = 1'b1; bus.Start = 1'b1; bus.T_in = 8'd20;
        @(negedge clk); bus.Abort = 1'b0; bus.Start = 1'b0; bus.T_in = 8'd0;
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL start_wins_busy got %b exp 1", bus.Busy); end
        checks++; if (bus.Error !== 1'b0) begin errors++; $display("FAIL start_clears_error got %b exp 0", bus.Error); end
        run_to_done(60, rdy, dn, to);
        checks++; if (to || dn != 1) begin errors++; $display("FAIL restart_done got %0d exp 1", dn); end
        checks++; if (bus.Error !== 1'b0) begin errors++; $display("FAIL restart_error got %b exp 0", bus.Error); end
    endtask

    task automatic test_busy_start;
        int rdy, dn; bit to;
        start_frame(8'd20);
        repeat (5) @(negedge clk);
        bus.Start = 1'b1; bus.T_in = 8'd99;
        @(negedge clk); bus.Start = 1'b0; bus.T_in = 8'd0;
        checks++; if (bus.Dp_T !== 8'd20) begin errors++; $display("FAIL busy_start_dp_t got %0d exp 20", bus.Dp_T); end
        checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL busy_start_busy got %b exp 1", bus.Busy); end
        run_to_done(60, rdy, dn, to);
        checks++; if (to || dn != 1) begin errors++; $display("FAIL busy_start_done got %0d exp 1", dn); end
        checks++; if (bus.Error !== 1'b0) begin errors++; $display("FAIL busy_start_error got %b exp 0", bus.Error); end
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b exp 0", bus.Busy); end
        checks++; if (bus.Result_Count !== 4'd15) begin errors++; $display("FAIL busy_start_count got %0d exp 15", bus.Result_Count); end
    endtask

    task automatic test_no_end;
        bit found;
        found = 1'b0;
        end_en = 1'b0;
        start_frame(8'd20);
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk);
            if (bus.Rd_Addr == 4'd15) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL no_end_last_addr got none exp 15"); end
`ifdef SOBEL_CTRL_WDOG_EN
        for (int c = 1; c <= DRAIN_MAX; c++) begin
            @(negedge clk);
            checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b1) begin errors++; $display("FAIL wdog_drain c=%0d got done=%b busy=%b exp 0 1", c, bus.Done, bus.Busy); end
        end
        @(negedge clk);
        checks++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL wdog_done got %b exp 1", bus.Done); end
        checks++; if (bus.Error !== 1'b1) begin errors++; $display("FAIL wdog_error got %b exp 1", bus.Error); end
`else
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b1) begin errors++; $display("FAIL drain_wait c=%0d got done=%b busy=%b exp 0 1", c, bus.Done, bus.Busy); end
        end
        bus.Abort = 1'b1;
        @(negedge clk); bus.Abort = 1'b0;
        checks++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL drain_abort_done got %b exp 1", bus.Done); end
        checks++; if (bus.Error !== 1'b1) begin errors++; $display("FAIL drain_abort_error got %b exp 1", bus.Error); end
`endif
        @(negedge clk);
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL no_end_idle got %b exp 0", bus.Busy); end
        end_en = 1'b1;
    endtask

    task automatic test_reset_mid_frame;
        bit found;
        found = 1'b0;
        start_frame(8'd20);
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk);
            if (bus.Rd_Addr == 4'd5) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL midrst_addr5 got none exp 5"); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", bus.Busy); end
        checks++; if (bus.Dp_Reset !== 1'b1) begin errors++; $display("FAIL midrst_dp_reset got %b exp 1", bus.Dp_Reset); end
        checks++; if (bus.Rd_Addr !== 4'd0) begin errors++; $display("FAIL midrst_rd_addr got %0d exp 0", bus.Rd_Addr); end
        checks++; if (bus.Dp_T !== 8'd0) begin errors++; $display("FAIL midrst_dp_t got %0d exp 0", bus.Dp_T); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", bus.Done); end
        checks++; if (bus.Dp_Enable !== 1'b0) begin errors++; $display("FAIL midrst_enable got %b exp 0", bus.Dp_Enable); end
        checks++; if (bus.Result_Count !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", bus.Result_Count); end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin errors++; $display("FAIL midrst_quiet got done=%b busy=%b exp 0 0", bus.Done, bus.Busy); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < NPIX; i++) rom[i] = 8'(i * 13 + 7);
        test_reset();
        test_frame();
        test_write_path();
        test_abort();
        test_busy_start();
        test_no_end();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
